pc_fetch_unit: RTL and testbench

Program-counter stage of the MIPS datapath: holds the current fetch address and drives it straight into the instruction memory's PC input, which returns the instruction word combinationally in the same cycle. It computes the next PC from sequential flow, conditional branches, `j`/`jal` and `jr`, supports a stall hold, and counts retired fetches. An optional address checker halts fetch on a misaligned or out-of-range target.

---
 rtl/mips_pkg.sv | 18 +
 rtl/npc_calc.sv | 28 ++
 rtl/pc_fetch_unit.sv | 103 ++++++++++
 tb/tb_pc_fetch_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: next-PC select encodings and the default code-segment base.
package mips_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_JR     = 2'd3
    } npc_op_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Branch offset is in words; sign-extend and scale to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC mux and adder for the fetch stage.
module npc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  npc_op,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    output logic [31:0] npc,
    output logic [31:0] pc_plus4
);

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        npc = pc_plus4;
        unique case (npc_op)
            NPC_SEQ:    npc = pc_plus4;
            NPC_BRANCH: npc = branch_taken ? (pc_plus4 + branch_offset(imm16)) : pc_plus4;
            NPC_JUMP:   npc = {pc_plus4[31:28], instr_index, 2'b00};
            NPC_JR:     npc = jr_target;
            default:    npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch counter and optional address checker (enable with PC_ADDR_CHECK_EN).
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned ADR_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] fetch_count,
    output logic        halted,
    output logic [31:0] fault_addr
);

    logic [31:0] pc_q;
    logic [31:0] count_q;
    logic [31:0] npc;

    npc_calc u_npc_calc (
        .pc           (pc_q),
        .npc_op       (npc_op),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .instr_index  (instr_index),
        .jr_target    (jr_target),
        .npc          (npc),
        .pc_plus4     (pc_plus4)
    );

    assign pc          = pc_q;
    assign fetch_count = count_q;

`ifdef PC_ADDR_CHECK_EN

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    // 33-bit bounds so a window ending at 2^32 does not wrap.
    localparam logic [32:0] WinLo = {1'b0, RESET_PC};
    localparam logic [32:0] WinHi = {1'b0, RESET_PC} + (33'd4 << ADR_BITS);

    state_e      state_q;
    logic        halted_q;
    logic [31:0] fault_q;
    logic        npc_ok;

    assign npc_ok = (npc[1:0] == 2'b00) && ({1'b0, npc} >= WinLo) && ({1'b0, npc} < WinHi);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StRun;
            pc_q     <= RESET_PC;
            count_q  <= 32'd0;
            halted_q <= 1'b0;
            fault_q  <= 32'd0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (!stall) begin
                        if (npc_ok) begin
                            pc_q    <= npc;
                            count_q <= count_q + 32'd1;
                        end else begin
                            state_q  <= StHalt;
                            halted_q <= 1'b1;
                            fault_q  <= npc;
                        end
                    end
                end
                StHalt: ;
                default: state_q <= StHalt;
            endcase
        end
    end

    assign halted     = halted_q;
    assign fault_addr = fault_q;

`else

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            count_q <= 32'd0;
        end else if (!stall) begin
            pc_q    <= npc;
            count_q <= count_q + 32'd1;
        end
    end

    assign halted     = 1'b0;
    assign fault_addr = 32'd0;

`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; covers the PC_ADDR_CHECK_EN build when defined.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_op;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_count;
    logic        halted;
    logic [31:0] fault_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .npc_op       (npc_op),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .instr_index  (instr_index),
        .jr_target    (jr_target),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .fetch_count  (fetch_count),
        .halted       (halted),
        .fault_addr   (fault_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present controls, let one rising edge pass, then settle before sampling.
    task automatic step(input logic [1:0] op, input logic tk, input logic [15:0] imm,
                        input logic [25:0] idx, input logic [31:0] jr, input logic st);
        npc_op       = op;
        branch_taken = tk;
        imm16        = imm;
        instr_index  = idx;
        jr_target    = jr;
        stall        = st;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        npc_op = 2'd0;
        branch_taken = 1'b0;
        imm16 = 16'h0;
        instr_index = 26'h0;
        jr_target = 32'h0;
        @(posedge clk);
        #1;
        do_reset();

        check("reset_pc", pc, 32'h3000);
        check("reset_pc_plus4", pc_plus4, 32'h3004);
        check("reset_count", fetch_count, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);
        check("reset_fault", fault_addr, 32'd0);

        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        check("seq1", pc, 32'h3004);
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        check("seq2", pc, 32'h3008);
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        check("seq3", pc, 32'h300C);
        check("seq_count", fetch_count, 32'd3);
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        check("seq4", pc, 32'h3010);

        // 0x3014 + (-4 words) = 0x3004
        step(2'd1, 1'b1, 16'hFFFC, 26'h0, 32'h0, 1'b0);
        check("br_taken", pc, 32'h3004);
        check("br_taken_count", fetch_count, 32'd5);
        for (int i = 0; i < 3; i++) step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        check("back_to_3010", pc, 32'h3010);
        step(2'd1, 1'b0, 16'hFFFC, 26'h0, 32'h0, 1'b0);
        check("br_not_taken", pc, 32'h3014);
        check("br_not_taken_count", fetch_count, 32'd9);

        do_reset();
        check("rst2_pc", pc, 32'h3000);
        check("rst2_count", fetch_count, 32'd0);
        step(2'd2, 1'b0, 16'h0, 26'h0000C10, 32'h0, 1'b0);
        check("jump", pc, 32'h3040);
        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h3100, 1'b0);
        check("jr", pc, 32'h3100);
        check("jr_pc_plus4", pc_plus4, 32'h3104);
        check("jr_count", fetch_count, 32'd2);

        for (int i = 0; i < 4; i++) begin
            step(2'd3, 1'b0, 16'h0, 26'h0, 32'h3002, 1'b1);
            check("stall_pc", pc, 32'h3100);
            check("stall_count", fetch_count, 32'd2);
            check("stall_halted", {31'd0, halted}, 32'd0);
        end

`ifdef PC_ADDR_CHECK_EN
        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h3002, 1'b0);
        check("mis_halted", {31'd0, halted}, 32'd1);
        check("mis_fault", fault_addr, 32'h3002);
        check("mis_pc_hold", pc, 32'h3100);
        check("mis_count_hold", fetch_count, 32'd2);
        for (int i = 0; i < 2; i++) begin
            step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
            check("halt_pc_hold", pc, 32'h3100);
            check("halt_fault_hold", fault_addr, 32'h3002);
        end
        do_reset();
        check("halt_rst_pc", pc, 32'h3000);
        check("halt_rst_halted", {31'd0, halted}, 32'd0);
        check("halt_rst_fault", fault_addr, 32'd0);

        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h3FFC, 1'b0);
        check("win_last_pc", pc, 32'h3FFC);
        check("win_last_halted", {31'd0, halted}, 32'd0);
        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h4000, 1'b0);
        check("win_hi_halted", {31'd0, halted}, 32'd1);
        check("win_hi_fault", fault_addr, 32'h4000);
        check("win_hi_pc", pc, 32'h3FFC);

        do_reset();
        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h2FFC, 1'b0);
        check("win_lo_fault", fault_addr, 32'h2FFC);
        check("win_lo_pc", pc, 32'h3000);
        check("win_lo_count", fetch_count, 32'd0);
`else
        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h4000, 1'b0);
        check("nochk_pc", pc, 32'h4000);
        check("nochk_halted", {31'd0, halted}, 32'd0);
        check("nochk_count", fetch_count, 32'd3);
        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h3002, 1'b0);
        check("nochk_mis_pc", pc, 32'h3002);
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        check("nochk_seq_pc", pc, 32'h3006);
        check("nochk_fault", fault_addr, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
